// File: rtl/apb_cmd_pkg.sv
// Shared types and default sizes for the APB command requester.
// The FIFO entry layout is fixed by the default widths below.
package apb_cmd_pkg;

   localparam int CMD_DATA_W  = 8;
   localparam int CMD_ADDR_W  = 4;
   localparam int CMD_DEPTH   = 4;
   localparam int CMD_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
   } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command FIFO with extra-MSB pointers.
// A push into a full FIFO is refused even when a pop happens in the same cycle.
module apb_cmd_fifo
   import apb_cmd_pkg::*;
#(
   parameter int DEPTH = CMD_DEPTH
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_push,
   input  apb_cmd_t i_cmd,
   input  logic     i_pop,
   output apb_cmd_t o_cmd,
   output logic     o_full,
   output logic     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   apb_cmd_t    r_mem [DEPTH];
   logic        w_wr;
   logic        w_rd;

   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign w_wr    = i_push && !o_full;
   assign w_rd    = i_pop && !o_empty;
   assign o_cmd   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_cmd;
   end

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: queues read/write commands and runs each through SETUP/ACCESS.
// One registered response per command; stuck slaves are aborted after TIMEOUT waits.
module apb_cmd_master
   import apb_cmd_pkg::*;
#(
   parameter int DATA_W  = CMD_DATA_W,
   parameter int ADDR_W  = CMD_ADDR_W,
   parameter int DEPTH   = CMD_DEPTH,
   parameter int TIMEOUT = CMD_TIMEOUT
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   localparam int CW = $clog2(TIMEOUT + 1);

   apb_state_e        r_state;
   apb_state_e        w_next;
   logic [CW-1:0]     r_wait;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_rsp_valid;
   logic              r_rsp_write;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;

   apb_cmd_t w_push_cmd;
   apb_cmd_t w_head;
   logic     w_full;
   logic     w_empty;
   logic     w_done;
   logic     w_abort;
   logic     w_pop;
   logic     w_psel;
   logic     w_penable;

   assign w_push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

   apb_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (PCLK),
      .i_rst_n (PRESETn),
      .i_push  (cmd_valid),
      .i_cmd   (w_push_cmd),
      .i_pop   (w_pop),
      .o_cmd   (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_done  = (r_state == ACCESS) && PREADY;
   assign w_abort = (r_state == ACCESS) && !PREADY &&
                    (r_wait == CW'(TIMEOUT - 1));
   // An abort never pops: the queue waits for a fresh pass through IDLE.
   assign w_pop   = !w_empty && ((r_state == IDLE) || w_done);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (!w_empty) w_next = SETUP;
         SETUP:   w_next = ACCESS;
         ACCESS: begin
            if (w_done)       w_next = w_empty ? IDLE : SETUP;
            else if (w_abort) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_psel    = 1'b0;
      w_penable = 1'b0;
      unique case (r_state)
         IDLE:    ;
         SETUP:   w_psel = 1'b1;
         ACCESS: begin
            w_psel    = 1'b1;
            w_penable = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_pwrite <= 1'b0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_wait   <= '0;
      end else begin
         if (w_pop) begin
            r_pwrite <= w_head.write;
            r_paddr  <= w_head.addr;
            r_pwdata <= w_head.wdata;
            r_wait   <= '0;
         end else if ((r_state == ACCESS) && !PREADY) begin
            r_wait   <= r_wait + 1'b1;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_done || w_abort;
         r_rsp_write <= (w_done || w_abort) && r_pwrite;
         r_rsp_rdata <= (w_done && !r_pwrite) ? PRDATA : '0;
         r_rsp_err   <= w_abort;
      end
   end

   assign cmd_ready = !w_full;
   assign busy      = !w_empty || (r_state != IDLE);
   assign PSELx     = w_psel;
   assign PENABLE   = w_penable;
   assign PWRITE    = r_pwrite;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: transaction-level model plus a small APB slave
// with programmable wait states, checked every cycle and by directed cases.
module tb_apb_cmd_master;

   localparam int DW      = 8;
   localparam int AW      = 4;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cmd_s;

   typedef struct {
      logic          w;
      logic [DW-1:0] d;
      logic          e;
      int            c;
      logic          ps;
   } rsp_s;

   logic          PCLK;
   logic          PRESETn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          busy;
   logic          PSELx;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = 0;
   int stalls = 0;
   int run = 0;
   int runmax = 0;
   rsp_s rlog[$];

   apb_cmd_master #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_write (rsp_write),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .PSELx     (PSELx),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // APB slave: memory plus a configurable number of low-PREADY cycles.
   logic [DW-1:0] smem [16];
   int wait_cfg = 0;
   int acc_idx = 0;

   initial begin
      PREADY = 1'b0;
      PRDATA = '0;
      for (int i = 0; i < 16; i++) smem[i] = '0;
      forever begin
         @(negedge PCLK);
         if (PSELx && PENABLE) begin
            PREADY = (acc_idx >= wait_cfg);
            acc_idx++;
            if (PREADY && PWRITE) smem[PADDR] = PWDATA;
            PRDATA = PWRITE ? '0 : smem[PADDR];
         end else begin
            acc_idx = 0;
            PREADY = 1'b0;
            PRDATA = '0;
         end
      end
   end

   // Transaction model: queue of commands, current transfer and its age.
   cmd_s          mq[$];
   logic [DW-1:0] mmem [16];
   bit            m_x = 0;
   int            m_k = 0;
   cmd_s          m_cur = '{1'b0, '0, '0};
   logic          m_rv = 0;
   logic          m_rw = 0;
   logic          m_re = 0;
   logic [DW-1:0] m_rd = '0;

   initial begin
      for (int i = 0; i < 16; i++) mmem[i] = '0;
      forever begin
         @(posedge PCLK or negedge PRESETn);
         if (!PRESETn) begin
            mq.delete();
            m_x = 0; m_k = 0;
            m_rv = 0; m_rw = 0; m_re = 0; m_rd = '0;
         end else begin
            bit   push;
            cmd_s nc;
            push = cmd_valid && (mq.size() < DEPTH);
            nc = '{cmd_write, cmd_addr, cmd_wdata};
            m_rv = 0; m_rw = 0; m_re = 0; m_rd = '0;
            if (!m_x) begin
               if (mq.size() > 0) begin
                  m_cur = mq.pop_front();
                  m_x = 1; m_k = 0;
               end
            end else if (m_k == 0) begin
               m_k = 1;
            end else if (PREADY) begin
               m_rv = 1;
               m_rw = m_cur.w;
               m_rd = m_cur.w ? '0 : mmem[m_cur.a];
               if (m_cur.w) mmem[m_cur.a] = m_cur.d;
               if (mq.size() > 0) begin
                  m_cur = mq.pop_front();
                  m_k = 0;
               end else begin
                  m_x = 0;
               end
            end else if (m_k == TIMEOUT) begin
               m_rv = 1; m_rw = m_cur.w; m_re = 1;
               m_x = 0;
            end else begin
               m_k++;
            end
            if (push) mq.push_back(nc);
         end
      end
   end

   // Per-cycle comparison against the model and response logging.
   initial begin
      forever begin
         @(negedge PCLK);
         if (PRESETn) begin
            chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
            chk("busy", busy, (mq.size() != 0) || m_x);
            chk("psel", PSELx, m_x);
            chk("penable", PENABLE, m_x && (m_k >= 1));
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_write", rsp_write, m_rw);
            chk("rsp_rdata", rsp_rdata, m_rd);
            chk("rsp_err", rsp_err, m_re);
            if (m_x) begin
               chk("paddr", PADDR, m_cur.a);
               chk("pwrite", PWRITE, m_cur.w);
               chk("pwdata", PWDATA, m_cur.d);
            end
            if (rsp_valid)
               rlog.push_back('{rsp_write, rsp_rdata, rsp_err, cyc, PSELx});
            if (PSELx) begin
               run++;
               if (run > runmax) runmax = run;
            end else begin
               run = 0;
            end
         end
      end
   end

   task automatic send(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      int n = 0;
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && n < 200) begin
         @(negedge PCLK);
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL send_accept: got no cmd_ready expected acceptance");
      end
      stalls += n;
      last_acc = cyc + 1;
   endtask

   task automatic idle();
      @(negedge PCLK);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n);
      int k = 0;
      while (rlog.size() < n && k < 100) begin
         @(negedge PCLK);
         #1;
         k++;
      end
      if (rlog.size() < n) begin
         checks++; errors++;
         $display("FAIL rsp_wait: got %0d responses expected %0d",
                  rlog.size(), n);
      end
   endtask

   function automatic rsp_s get(input int i);
      rsp_s r;
      r = '{1'bx, 'x, 1'bx, -1, 1'bx};
      if (i < rlog.size()) r = rlog[i];
      return r;
   endfunction

   initial begin
      int   base;
      int   acc1;
      rsp_s r;

      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      repeat (2) @(negedge PCLK);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_psel", PSELx, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_write", rsp_write, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      @(negedge PCLK);
      PRESETn = 1'b1;

      // single write then read
      wait_cfg = 0;
      base = rlog.size();
      send(1'b1, 4'h3, 8'hA5);
      idle();
      wait_rsp(base + 1);
      r = get(base);
      chk("wr_latency", r.c - last_acc, 3);
      chk("wr_rsp_write", r.w, 1);
      chk("wr_rsp_err", r.e, 0);
      chk("wr_rsp_rdata", r.d, 0);
      chk("wr_slave_mem", smem[3], 8'hA5);

      base = rlog.size();
      send(1'b0, 4'h3, 8'h00);
      idle();
      wait_rsp(base + 1);
      r = get(base);
      chk("rd_latency", r.c - last_acc, 3);
      chk("rd_rsp_write", r.w, 0);
      chk("rd_rsp_rdata", r.d, 8'hA5);
      chk("rd_rsp_err", r.e, 0);

      // three wait states
      wait_cfg = 3;
      base = rlog.size();
      send(1'b1, 4'h5, 8'h5A);
      idle();
      wait_rsp(base + 1);
      r = get(base);
      chk("ws_latency", r.c - last_acc, 6);
      chk("ws_rsp_write", r.w, 1);
      chk("ws_slave_mem", smem[5], 8'h5A);

      // back-to-back
      wait_cfg = 0;
      stalls = 0;
      runmax = 0;
      base = rlog.size();
      send(1'b1, 4'h1, 8'h21);
      send(1'b1, 4'h2, 8'h42);
      send(1'b0, 4'h1, 8'h00);
      send(1'b0, 4'h2, 8'h00);
      idle();
      wait_rsp(base + 4);
      chk("b2b_stalls", stalls, 0);
      chk("b2b_psel_run", runmax, 8);
      r = get(base + 2);
      chk("b2b_rd1", r.d, 8'h21);
      r = get(base + 3);
      chk("b2b_rd2", r.d, 8'h42);
      chk("b2b_rd2_write", r.w, 0);

      // full FIFO with a stalled transfer in flight
      wait_cfg = 255;
      base = rlog.size();
      for (int i = 0; i < 5; i++) send(1'b1, AW'(8 + i), DW'(8'h10 + i));
      idle();
      chk("full_ready", cmd_ready, 0);
      chk("full_busy", busy, 1);
      wait_cfg = 0;
      send(1'b0, 4'hA, 8'h00);
      idle();
      wait_rsp(base + 6);
      r = get(base + 5);
      chk("full_last_rdata", r.d, 8'h12);
      chk("full_last_err", r.e, 0);
      r = get(base);
      chk("full_first_err", r.e, 0);

      // timeout then a normal command
      wait_cfg = 255;
      base = rlog.size();
      send(1'b1, 4'h7, 8'h11);
      acc1 = last_acc;
      send(1'b0, 4'h3, 8'h00);
      idle();
      wait_rsp(base + 1);
      wait_cfg = 0;
      r = get(base);
      chk("to_latency", r.c - acc1, 3 + TIMEOUT - 1);
      chk("to_err", r.e, 1);
      chk("to_rdata", r.d, 0);
      chk("to_write", r.w, 1);
      chk("to_psel", r.ps, 0);
      chk("to_slave_mem", smem[7], 0);
      wait_rsp(base + 2);
      r = get(base + 1);
      chk("to_next_err", r.e, 0);
      chk("to_next_rdata", r.d, 8'hA5);

      // reset in the middle of an ACCESS with two queued commands
      wait_cfg = 255;
      send(1'b1, 4'hD, 8'h31);
      send(1'b1, 4'hE, 8'h32);
      send(1'b1, 4'hF, 8'h33);
      idle();
      repeat (2) @(negedge PCLK);
      chk("mid_penable", PENABLE, 1);
      chk("mid_busy", busy, 1);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("ar_psel", PSELx, 0);
      chk("ar_penable", PENABLE, 0);
      chk("ar_rsp_valid", rsp_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_cmd_ready", cmd_ready, 1);
      base = rlog.size();
      repeat (2) @(negedge PCLK);
      #2;
      PRESETn = 1'b1;
      wait_cfg = 0;
      repeat (10) @(negedge PCLK);
      #1;
      chk("ar_no_rsp", rlog.size(), base);
      chk("ar_idle_busy", busy, 0);
      chk("ar_slave_mem", smem[13], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB requester that sits directly upstream of the team's 8-bit/4-bit-address APB register slave and drives its PSELx/PENABLE/PWRITE/PADDR/PWDATA bus. It accepts read/write commands over a valid/ready interface, buffers them in a small FIFO, and sequences each command through the APB SETUP/ACCESS phases. Each command produces exactly one response pulse carrying read data or a timeout error.

## Interface
- DATA_W, 8: APB data width.
- ADDR_W, 4: APB address width.
- DEPTH, 4: command FIFO entries, power of two, at least 2.
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before abort, at least 1.
- PCLK  in  1: the single clock.
- PRESETn  in  1: asynchronous, active-low reset.
- cmd_valid  in  1: command offered.
- cmd_ready  out  1: equals !fifo_full.
- cmd_write  in  1: 1 = write, 0 = read.
- cmd_addr  in  ADDR_W: target address.
- cmd_wdata  in  DATA_W: write data, ignored for reads.
- rsp_valid  out  1: one-cycle response pulse.
- rsp_write  out  1: echoes the command type.
- rsp_rdata  out  DATA_W: PRDATA for reads; 0 for writes and on error.
- rsp_err  out  1: timeout abort.
- busy  out  1: FIFO non-empty or FSM not IDLE.
- PSELx, PENABLE, PWRITE  out  1: APB control.
- PADDR  out  ADDR_W; PWDATA  out  DATA_W: APB address and write data.
- PRDATA  in  DATA_W; PREADY  in  1: APB slave return.

## Operation
- Reset values: all outputs 0 except cmd_ready, which is 1. FIFO is emptied and the FSM is in IDLE.
- Command push happens on a PCLK edge with cmd_valid && cmd_ready. When full, the push is refused even if a pop occurs in the same cycle. Commands are issued strictly in FIFO order.
- FSM states:
  - IDLE: PSELx=0, PENABLE=0. If the FIFO is non-empty, pop the head, load PWRITE/PADDR/PWDATA, and go to SETUP.
  - SETUP: PSELx=1, PENABLE=0. Unconditionally go to ACCESS.
  - ACCESS: PSELx=1, PENABLE=1.
- ACCESS with PREADY=1 completes the transfer:
  - Capture PRDATA for reads, 0 for writes.
  - Pulse the response.
  - If the FIFO is non-empty, pop and go directly to SETUP (PSELx stays high, new address loaded). Otherwise go to IDLE.
- ACCESS with PREADY=0 increments wait_cnt. When wait_cnt reaches TIMEOUT-1 with PREADY still 0, abort:
  - Response pulse with rsp_err=1 and rsp_rdata=0.
  - Next state is IDLE, even if the FIFO is non-empty.
- wait_cnt clears on every SETUP entry. Its width is $clog2(TIMEOUT+1).
- PWRITE, PADDR and PWDATA are held stable from SETUP through the last ACCESS cycle. In IDLE they keep their last values.
- Reset asserted mid-transfer: the bus drops immediately (asynchronous), the in-flight command and FIFO contents are discarded, and no response is produced.

## Timing
- Single command into an empty, idle block, cmd accepted at edge 0:
  - SETUP after edge 1, ACCESS after edge 2.
  - Completion at edge 3 if PREADY=1.
  - rsp_valid high for the cycle after edge 3.
- Minimum latency from cmd acceptance to rsp_valid is 3 cycles. Each PREADY=0 ACCESS cycle adds 1.
- Back-to-back commands: 2 cycles per transfer with no IDLE between them.
- rsp_* are registered; rsp_write, rsp_rdata and rsp_err are valid only while rsp_valid=1 and return to 0 afterwards.
- Abort: rsp_valid with rsp_err=1 appears the cycle after the TIMEOUT-th low-PREADY ACCESS cycle. PSELx and PENABLE are 0 in that same cycle.

## Structure
- Package apb_cmd_pkg:
  - state enum apb_state_e {IDLE, SETUP, ACCESS}.
  - packed struct apb_cmd_t {write, addr, wdata}.
  - default width constants.
- Sub-module apb_cmd_fifo: synchronous FIFO of apb_cmd_t, DEPTH entries, with full/empty flags and wrap-around pointers that carry an extra MSB.
- The top level holds the FSM, wait counter and response registers.

## Test plan
- Single write then read: write addr 4'h3 data 8'hA5 with PREADY tied 1 -> APB write seen; rsp_valid 3 cycles after acceptance with rsp_write=1. Read of 4'h3 with slave PRDATA=8'hA5 -> rsp_rdata=8'hA5, rsp_err=0.
- Back-to-back: push 4 commands in 4 consecutive cycles (DEPTH=4) -> cmd_ready never drops, 4 transfers at 2 cycles each, PSELx continuously high, responses in order.
- Full FIFO: hold PREADY=0 and push 6 commands -> cmd_ready=0 once 4 are queued and one is in flight; the refused command is not lost and is accepted later.
- Wait states: PREADY low for 3 ACCESS cycles then high -> PADDR/PWDATA stable throughout; rsp_valid 6 cycles after acceptance.
- Timeout: PREADY stuck 0 with TIMEOUT=16 -> after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, FSM back in IDLE; the next queued command proceeds normally.
- Reset mid-ACCESS with 2 queued commands -> PSELx/PENABLE drop asynchronously, no rsp_valid, busy=0, cmd_ready=1.
